pc_gen: RTL and testbench

Parametrised program-counter generator for the fetch stage of the pipelined CPU. Holds the fetch PC; advances by a fixed increment, stalls, and takes redirects from the exception unit, the EX-stage branch resolver and the ID-stage jump decoder under a fixed priority. A redirect that arrives during a stall is buffered and applied on the first non-stalled cycle. An optional alignment checker converts misaligned targets into an exception redirect.

---
 rtl/pc_gen.sv | 123 ++++++++++++
 tb/tb_pc_gen.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch program-counter generator: increment, stall, prioritised redirects (exc > br > jmp > buffered).
// Latency: one cycle from redirect/increment to pc_o; pc_plus_o is combinational from pc_o.
// Backpressure: pc_write=0 holds pc_o and buffers one redirect; PC_ALIGN_CHECK_EN traps misaligned targets.
module pc_gen #(
   parameter int              PC_W      = 32,
   parameter logic [PC_W-1:0] RESET_VEC = 'h0000_0000,
   parameter logic [PC_W-1:0] EXC_VEC   = 'h8000_0004,
   parameter int              INC       = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            pc_write,
   input  logic            flush_exc,
   input  logic            br_valid,
   input  logic [PC_W-1:0] br_target,
   input  logic            jmp_valid,
   input  logic [PC_W-1:0] jmp_target,
   output logic [PC_W-1:0] pc_o,
   output logic [PC_W-1:0] pc_plus_o,
   output logic            redirect_pending_o,
   output logic            misalign_o,
   output logic [PC_W-1:0] badaddr_o
);

   typedef enum logic {
      KIND_BR  = 1'b0,
      KIND_JMP = 1'b1
   } kind_e;

   typedef struct packed {
      logic            vld;
      kind_e           kind;
      logic [PC_W-1:0] target;
   } pend_t;

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_nxt;
   pend_t           pend_q;
   pend_t           pend_nxt;
   logic            load_en;
   logic [PC_W-1:0] load_tgt;
   logic            trap;

   assign pc_plus_o          = pc_q + PC_W'(INC);
   assign pc_o               = pc_q;
   assign redirect_pending_o = pend_q.vld;

`ifdef PC_ALIGN_CHECK_EN
   localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'(INC - 1);
   assign trap = load_en && ((load_tgt & ALIGN_MASK) != '0);
`else
   assign trap = 1'b0;
`endif

   always_comb begin
      pc_nxt   = pc_q;
      pend_nxt = pend_q;
      load_en  = 1'b0;
      load_tgt = '0;
      if (flush_exc) begin
         pc_nxt       = EXC_VEC;
         pend_nxt.vld = 1'b0;
      end else if (pc_write) begin
         pend_nxt.vld = 1'b0;
         if (br_valid) begin
            load_en  = 1'b1;
            load_tgt = br_target;
         end else if (jmp_valid) begin
            load_en  = 1'b1;
            load_tgt = jmp_target;
         end else if (pend_q.vld) begin
            load_en  = 1'b1;
            load_tgt = pend_q.target;
         end else begin
            pc_nxt = pc_plus_o;
         end
         if (load_en) begin
            pc_nxt = trap ? EXC_VEC : load_tgt;
         end
      end else begin
         // A buffered branch is older than any jump, so a jump never displaces it.
         if (br_valid) begin
            pend_nxt = '{vld: 1'b1, kind: KIND_BR, target: br_target};
         end else if (jmp_valid && (!pend_q.vld || pend_q.kind == KIND_JMP)) begin
            pend_nxt = '{vld: 1'b1, kind: KIND_JMP, target: jmp_target};
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q   <= RESET_VEC;
         pend_q <= '0;
      end else begin
         pc_q   <= pc_nxt;
         pend_q <= pend_nxt;
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   logic            misalign_q;
   logic [PC_W-1:0] badaddr_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         misalign_q <= 1'b0;
         badaddr_q  <= '0;
      end else begin
         misalign_q <= trap;
         if (trap) begin
            badaddr_q <= load_tgt;
         end
      end
   end

   assign misalign_o = misalign_q;
   assign badaddr_o  = badaddr_q;
`else
   assign misalign_o = 1'b0;
   assign badaddr_o  = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        pc_write = 1'b0;
   logic        flush_exc = 1'b0;
   logic        br_valid = 1'b0;
   logic [31:0] br_target = '0;
   logic        jmp_valid = 1'b0;
   logic [31:0] jmp_target = '0;
   logic [31:0] pc_o;
   logic [31:0] pc_plus_o;
   logic        redirect_pending_o;
   logic        misalign_o;
   logic [31:0] badaddr_o;

   int tests = 0;
   int fails = 0;

   pc_gen dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .pc_write           (pc_write),
      .flush_exc          (flush_exc),
      .br_valid           (br_valid),
      .br_target          (br_target),
      .jmp_valid          (jmp_valid),
      .jmp_target         (jmp_target),
      .pc_o               (pc_o),
      .pc_plus_o          (pc_plus_o),
      .redirect_pending_o (redirect_pending_o),
      .misalign_o         (misalign_o),
      .badaddr_o          (badaddr_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        pw;
      logic        fl;
      logic        bv;
      logic [31:0] bt;
      logic        jv;
      logic [31:0] jt;
      logic [31:0] epc;
      logic        epend;
      logic        emis;
      logic [31:0] ebad;
   } vec_t;

   vec_t sb[$];
   vec_t tbl[26];

   function automatic vec_t mk(input logic pw, input logic fl, input logic bv, input logic [31:0] bt,
                               input logic jv, input logic [31:0] jt, input logic [31:0] epc,
                               input logic epend);
      vec_t v;
      v.pw = pw; v.fl = fl; v.bv = bv; v.bt = bt; v.jv = jv; v.jt = jt;
      v.epc = epc; v.epend = epend; v.emis = 1'b0; v.ebad = 32'h0;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      pc_write = 1'b0; flush_exc = 1'b0; br_valid = 1'b0; jmp_valid = 1'b0;
   endtask

   // Drive one cycle of stimulus, push its expectation, then pop and compare after the edge.
   task automatic step(input vec_t v, input string name);
      vec_t e;
      @(negedge clk);
      pc_write = v.pw; flush_exc = v.fl;
      br_valid = v.bv; br_target = v.bt;
      jmp_valid = v.jv; jmp_target = v.jt;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({name, "_pc"}, pc_o, e.epc);
      chk({name, "_plus"}, pc_plus_o, e.epc + 32'd4);
      chk({name, "_pend"}, {31'd0, redirect_pending_o}, {31'd0, e.epend});
      chk({name, "_mis"}, {31'd0, misalign_o}, {31'd0, e.emis});
      chk({name, "_bad"}, badaddr_o, e.ebad);
   endtask

   initial begin
      vec_t v;

      tbl[0]  = mk(1, 0, 0, 0,            0, 0,            32'h4,          0);
      tbl[1]  = mk(1, 0, 0, 0,            0, 0,            32'h8,          0);
      tbl[2]  = mk(1, 0, 0, 0,            0, 0,            32'hC,          0);
      tbl[3]  = mk(1, 0, 0, 0,            0, 0,            32'h10,         0);
      tbl[4]  = mk(1, 0, 1, 32'h100,      1, 32'h200,      32'h100,        0);
      tbl[5]  = mk(1, 0, 0, 0,            1, 32'h20,       32'h20,         0);
      tbl[6]  = mk(0, 0, 0, 0,            1, 32'h300,      32'h20,         1);
      tbl[7]  = mk(0, 0, 1, 32'h400,      0, 0,            32'h20,         1);
      tbl[8]  = mk(0, 0, 0, 0,            0, 0,            32'h20,         1);
      tbl[9]  = mk(1, 0, 0, 0,            0, 0,            32'h400,        0);
      tbl[10] = mk(0, 0, 1, 32'h500,      0, 0,            32'h400,        1);
      tbl[11] = mk(0, 1, 0, 0,            0, 0,            32'h8000_0004,  0);
      tbl[12] = mk(1, 0, 0, 0,            0, 0,            32'h8000_0008,  0);
      tbl[13] = mk(0, 0, 1, 32'h600,      0, 0,            32'h8000_0008,  1);
      tbl[14] = mk(0, 0, 0, 0,            1, 32'h700,      32'h8000_0008,  1);
      tbl[15] = mk(1, 0, 0, 0,            0, 0,            32'h600,        0);
      tbl[16] = mk(0, 0, 0, 0,            1, 32'h700,      32'h600,        1);
      tbl[17] = mk(0, 0, 0, 0,            1, 32'h740,      32'h600,        1);
      tbl[18] = mk(1, 0, 0, 0,            0, 0,            32'h740,        0);
      tbl[19] = mk(0, 0, 1, 32'h800,      0, 0,            32'h740,        1);
      tbl[20] = mk(1, 0, 0, 0,            1, 32'h900,      32'h900,        0);
      tbl[21] = mk(1, 1, 1, 32'hA00,      0, 0,            32'h8000_0004,  0);
      tbl[22] = mk(1, 0, 0, 0,            1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0);
      tbl[23] = mk(1, 0, 0, 0,            0, 0,            32'h0,          0);
      tbl[24] = mk(0, 0, 1, 32'hB00,      1, 32'hC00,      32'h0,          1);
      tbl[25] = mk(1, 0, 0, 0,            0, 0,            32'hB00,        0);

      #1 reset_n = 1'b0;
      #1;
      chk("rst_pc", pc_o, 32'h0);
      chk("rst_plus", pc_plus_o, 32'h4);
      chk("rst_pend", {31'd0, redirect_pending_o}, 32'h0);
      chk("rst_mis", {31'd0, misalign_o}, 32'h0);
      chk("rst_bad", badaddr_o, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 26; i++) begin
         step(tbl[i], $sformatf("v%0d", i));
      end

      // Misaligned branch target: trapped with the check enabled, loaded as-is otherwise.
      v = mk(1, 0, 1, 32'h102, 0, 0, 32'h102, 0);
`ifdef PC_ALIGN_CHECK_EN
      v.epc = 32'h8000_0004; v.emis = 1'b1; v.ebad = 32'h102;
`endif
      step(v, "mis_load");
      v = mk(1, 0, 0, 0, 0, 0, 32'h106, 0);
`ifdef PC_ALIGN_CHECK_EN
      v.epc = 32'h8000_0008; v.ebad = 32'h102;
`endif
      step(v, "mis_after");

      // Asynchronous reset in the middle of a stall discards the buffered redirect.
      v = mk(0, 0, 1, 32'hD00, 0, 0, pc_o, 1);
`ifdef PC_ALIGN_CHECK_EN
      v.ebad = 32'h102;
`endif
      step(v, "pre_arst");
      idle();
      #3 reset_n = 1'b0;
      #1;
      chk("arst_pc", pc_o, 32'h0);
      chk("arst_pend", {31'd0, redirect_pending_o}, 32'h0);
      chk("arst_bad", badaddr_o, 32'h0);
      #1 reset_n = 1'b1;
      step(mk(0, 0, 0, 0, 0, 0, 32'h0, 0), "post_arst_hold");
      step(mk(1, 0, 0, 0, 0, 0, 32'h4, 0), "post_arst_inc");

      idle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
